// File: rtl/line_scheduler.sv
// Line scheduler: buffers source lines in a small FIFO and issues them one at a
// time to the Controller with a load strobe. Optional watchdog: LINE_SCHED_WATCHDOG_EN.
module line_scheduler #(
  parameter int unsigned LINE_W    = 25,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned NUM_LINES = 64,
  parameter int unsigned IDX_W     = 6,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LINE_W-1:0] in_line,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [LINE_W-1:0] line,
  output logic              initLine,
  input  logic              done,
  output logic              busy,
  output logic              all_done,
  output logic [IDX_W-1:0]  line_idx,
  output logic              timeout_err
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("line_scheduler: DEPTH must be a power of 2 and at least 2");
  end
  if (TIMEOUT == 0 || (64'(1) << IDX_W) < 64'(NUM_LINES) || NUM_LINES == 0) begin : g_bad_cfg
    $error("line_scheduler: TIMEOUT must be nonzero and IDX_W must cover NUM_LINES");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_ISSUE,
    S_WAIT,
    S_FINISH
  } state_t;

  state_t state_q, state_d;

  logic [LINE_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count, count_d;
  logic              push, pop;
  logic              line_done;

  logic [LINE_W-1:0] line_d;
  logic              init_d, busy_d, all_done_d;
  logic [IDX_W-1:0]  idx_d;

  assign push = in_valid && in_ready;

`ifdef LINE_SCHED_WATCHDOG_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_cnt;
  logic            wd_hit;

  // Counter is zero everywhere outside WAIT, so it restarts on every WAIT entry.
  assign wd_hit    = (state_q == S_WAIT) && !done && (wd_cnt == WD_W'(TIMEOUT - 1));
  assign line_done = done || wd_hit;

  always_ff @(posedge clk) begin
    if (rst || state_q != S_WAIT) begin
      wd_cnt <= '0;
    end else begin
      wd_cnt <= wd_cnt + WD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      timeout_err <= 1'b0;
    end else if (state_q == S_IDLE && start) begin
      timeout_err <= 1'b0;
    end else if (wd_hit) begin
      timeout_err <= 1'b1;
    end
  end
`else
  assign line_done   = done;
  assign timeout_err = 1'b0;
`endif

  // Next-state and registered-output values.
  always_comb begin
    state_d    = state_q;
    line_d     = line;
    init_d     = 1'b0;
    busy_d     = busy;
    all_done_d = all_done;
    idx_d      = line_idx;
    pop        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d    = S_FETCH;
          busy_d     = 1'b1;
          all_done_d = 1'b0;
          idx_d      = '0;
        end
      end
      S_FETCH: begin
        if (count != '0) begin
          pop     = 1'b1;
          line_d  = mem[rd_ptr];
          init_d  = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (line_done) begin
          if (line_idx == IDX_W'(NUM_LINES - 1)) begin
            state_d    = S_FINISH;
            busy_d     = 1'b0;
            all_done_d = 1'b1;
          end else begin
            idx_d   = line_idx + IDX_W'(1);
            state_d = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      line     <= '0;
      initLine <= 1'b0;
      busy     <= 1'b0;
      all_done <= 1'b0;
      line_idx <= '0;
    end else begin
      state_q  <= state_d;
      line     <= line_d;
      initLine <= init_d;
      busy     <= busy_d;
      all_done <= all_done_d;
      line_idx <= idx_d;
    end
  end

  always_comb begin
    count_d = count;
    if (push && !pop) begin
      count_d = count + CNT_W'(1);
    end else if (pop && !push) begin
      count_d = count - CNT_W'(1);
    end
  end

  // FIFO bookkeeping; in_ready is registered from the next occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count    <= count_d;
      in_ready <= (count_d != CNT_W'(DEPTH));
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_line;
    end
  end

endmodule

// File: tb/tb_line_scheduler.sv
// Bench for line_scheduler: randomized source and Controller responses checked
// against a transaction-level model (line queue plus issue-time rules).
module tb_line_scheduler;

  localparam int LINE_W    = 25;
  localparam int DEPTH     = 4;
  localparam int NUM_LINES = 64;
  localparam int IDX_W     = 6;
  localparam int TIMEOUT   = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              start = 1'b0;
  logic [LINE_W-1:0] in_line = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [LINE_W-1:0] line;
  logic              initLine;
  logic              done = 1'b0;
  logic              busy;
  logic              all_done;
  logic [IDX_W-1:0]  line_idx;
  logic              timeout_err;

  line_scheduler #(
    .LINE_W(LINE_W), .DEPTH(DEPTH), .NUM_LINES(NUM_LINES), .IDX_W(IDX_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .in_line(in_line), .in_valid(in_valid),
    .in_ready(in_ready), .line(line), .initLine(initLine), .done(done), .busy(busy),
    .all_done(all_done), .line_idx(line_idx), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [LINE_W-1:0] v;
    int                t;
  } ent_t;

  ent_t              q[$];
  logic [LINE_W-1:0] src[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int pulses = 0;

  // Model state: run flags, issue eligibility edge, pending done window.
  bit                exp_busy = 0, exp_alldone = 0, exp_terr = 0;
  bit                armed = 0, waiting = 0;
  int                earliest = 0, issue_edge = 0, idle_edge = 0;
  int                exp_idx = 0;
  logic [LINE_W-1:0] exp_line = '0;

  int src_pct = 100;
  int dly = 1;
  int done_cnt = 0;
  bit hold_done = 0;
  bit stray_en = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h cycle=%0d", tag, obs, exp, cyc);
    end
  endtask

  task automatic drive_src();
    if (src.size() != 0 && $urandom_range(0, 99) < src_pct) begin
      in_valid = 1'b1;
      in_line  = src[0];
    end else begin
      in_valid = 1'b0;
      in_line  = LINE_W'($urandom);
    end
  endtask

  task automatic tick();
    bit   ready0, exp_init, fire, d_now;
    ent_t e;
    @(posedge clk);
    cyc++;
    ready0   = (q.size() != DEPTH);
    exp_init = 0;
    if (rst) begin
      q.delete();
      exp_busy = 0; exp_alldone = 0; exp_terr = 0; exp_idx = 0; exp_line = '0;
      armed = 0; waiting = 0; idle_edge = cyc;
    end else begin
      // A line is issued at the first edge where the run is fetching and the line has landed.
      if (armed && q.size() != 0 && cyc >= earliest && cyc >= q[0].t + 1) begin
        exp_init = 1;
        e = q.pop_front();
        exp_line = e.v;
        armed = 0; waiting = 1; issue_edge = cyc;
      end
      if (waiting && cyc >= issue_edge + 2) begin
        fire = done;
`ifdef LINE_SCHED_WATCHDOG_EN
        if (!done && cyc == issue_edge + 1 + TIMEOUT) begin
          fire = 1;
          exp_terr = 1;
        end
`endif
        if (fire) begin
          waiting = 0;
          if (exp_idx == NUM_LINES - 1) begin
            exp_busy = 0; exp_alldone = 1; idle_edge = cyc + 1;
          end else begin
            exp_idx++; armed = 1; earliest = cyc + 1;
          end
        end
      end
      if (start && !exp_busy && cyc > idle_edge) begin
        exp_busy = 1; exp_alldone = 0; exp_idx = 0; exp_terr = 0;
        armed = 1; earliest = cyc + 1; pulses = 0;
      end
      if (in_valid && ready0) begin
        q.push_back('{v: in_line, t: cyc});
        void'(src.pop_front());
      end
    end
    #1;
    if (initLine === 1'b1) pulses++;
    chk("initLine", 32'(initLine), 32'(exp_init));
    chk("line", 32'(line), 32'(exp_line));
    chk("line_idx", 32'(line_idx), 32'(exp_idx));
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("all_done", 32'(all_done), 32'(exp_alldone));
    chk("in_ready", 32'(in_ready), 32'(q.size() != DEPTH));
    chk("timeout_err", 32'(timeout_err), 32'(exp_terr));
    // Controller response: done pulse dly cycles into WAIT, optional ignored done in ISSUE.
    if (exp_init) done_cnt = ((dly != 0) ? dly : int'($urandom_range(1, 4))) + 1;
    d_now = 0;
    if (done_cnt > 0) begin
      done_cnt--;
      d_now = (done_cnt == 0);
    end
    done = !hold_done && (d_now || (stray_en && exp_init && $urandom_range(0, 1) == 1));
    drive_src();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int budget);
    int n = 0;
    while (!exp_alldone && n < budget) begin
      tick();
      n++;
    end
    chk("run_complete", 32'(all_done), 32'd1);
  endtask

  initial begin
    int n;
    // Reset then idle
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    repeat (5) tick();

    // Prefill four lines, then run with done two cycles after each strobe
    src = '{25'h0000001, 25'h0000002, 25'h0000003, 25'h0000004};
    src_pct = 100;
    drive_src();
    n = 0;
    while (src.size() != 0 && n < 20) begin tick(); n++; end
    tick();
    chk("prefill_full", 32'(in_ready), 32'd0);
    dly = 2;
    pulse_start();
    n = 0;
    while (pulses < 4 && n < 40) begin tick(); n++; end
    chk("prefill_pulses", 32'(pulses), 32'd4);

    // Starvation in FETCH, then random feeding through the rest of the run
    repeat (10) tick();
    chk("starve_pulses", 32'(pulses), 32'd4);
    src.push_back(25'h1FFFFFF);
    for (int i = 0; i < NUM_LINES - 5; i++) src.push_back(LINE_W'($urandom));
    src_pct = 50;
    dly = 0;
    stray_en = 1;
    drive_src();
    run_to_done(3000);
    chk("run1_pulses", 32'(pulses), 32'(NUM_LINES));
    stray_en = 0;

    // Full run, Mem[i]=i, done one cycle after each strobe
    repeat (3) tick();
    for (int i = 0; i < NUM_LINES; i++) src.push_back(LINE_W'(i));
    src_pct = 100;
    dly = 1;
    drive_src();
    pulse_start();
    run_to_done(2000);
    chk("run2_pulses", 32'(pulses), 32'(NUM_LINES));
    chk("run2_idx", 32'(line_idx), 32'(NUM_LINES - 1));
    chk("run2_busy", 32'(busy), 32'd0);

    // Leftovers retained, then a reset while waiting on line 5
    for (int i = 0; i < 2; i++) src.push_back(LINE_W'($urandom));
    drive_src();
    n = 0;
    while (src.size() != 0 && n < 20) begin tick(); n++; end
    tick();
    for (int i = 0; i < 20; i++) src.push_back(LINE_W'($urandom));
    src_pct = 70;
    dly = 3;
    pulse_start();
    n = 0;
    while (!(waiting && exp_idx == 5 && cyc > issue_edge) && n < 500) begin tick(); n++; end
    chk("reach_idx5", 32'(line_idx), 32'd5);
    rst = 1'b1;
    src.delete();
    done_cnt = 0;
    done = 1'b0;
    drive_src();
    tick();
    rst = 1'b0;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_idx", 32'(line_idx), 32'd0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    done = 1'b1;
    tick();
    repeat (6) tick();
    chk("stray_done_idle", 32'(busy), 32'd0);

`ifdef LINE_SCHED_WATCHDOG_EN
    // Withheld done: line 0 is abandoned after TIMEOUT WAIT cycles and line 1 follows
    for (int i = 0; i < 3; i++) src.push_back(LINE_W'($urandom));
    src_pct = 100;
    drive_src();
    hold_done = 1;
    pulse_start();
    n = 0;
    while (pulses < 2 && n < 100) begin tick(); n++; end
    chk("wd_pulses", 32'(pulses), 32'd2);
    chk("wd_flag", 32'(timeout_err), 32'd1);
    repeat (4) tick();
    chk("wd_sticky", 32'(timeout_err), 32'd1);
    hold_done = 0;
    rst = 1'b1;
    src.delete();
    done_cnt = 0;
    done = 1'b0;
    drive_src();
    tick();
    rst = 1'b0;
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
